// File: rtl/gray_store_pkg.sv
// Shared types and constants for the grayscale store controller.
// Build with GRAY_PACKED_EN defined to store one byte per pixel instead of three.
package gray_store_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_e;

`ifdef GRAY_PACKED_EN
   localparam int BYTES_PER_PIXEL = 1;
`else
   localparam int BYTES_PER_PIXEL = 3;
`endif

   localparam int MEM_BYTES_DEF = 51200;
   localparam int ADDR_W_DEF    = 16;
   localparam int CNT_W_DEF     = 16;

   // Phase value of the final byte of a pixel; always 0 in the packed build.
   localparam logic [1:0] LAST_PHASE = 2'(BYTES_PER_PIXEL - 1);

endpackage

// File: rtl/gray_store_ctrl_if.sv
// Pixel input handshake, frame control and byte-wide memory write port.
interface gray_store_ctrl_if
   import gray_store_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
);
   // A pixel transfers on a rising clk edge where in_valid and in_ready are both
   // high; in_data is ignored otherwise. The producer holds in_data stable while
   // in_valid is high and in_ready is low.
   logic              start;
   logic [CNT_W-1:0]  npix;
   logic              abort;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, npix, abort, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
   );

   modport slave (
      input  start, npix, abort, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err
   );

endinterface

// File: rtl/gray_store_addr_gen.sv
// Byte address, byte-phase and pixel counters for one frame, plus last-pixel flags
// for the current and the following cycle.
module gray_store_addr_gen
   import gray_store_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic              advance_i,
   input  logic [CNT_W-1:0]  npix_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic [1:0]        phase_o,
   output logic [1:0]        phase_nxt_o,
   output logic              last_o,
   output logic              last_nxt_o
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        phase_q, phase_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  npix_q, npix_d;

   assign last_o = (cnt_q == npix_q - CNT_W'(1));

   always_comb begin
      addr_d  = addr_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      npix_d  = npix_q;
      if (clear_i) begin
         addr_d  = '0;
         phase_d = '0;
         cnt_d   = '0;
         npix_d  = npix_i;
      end else if (advance_i) begin
         if (phase_q == LAST_PHASE) begin
            phase_d = '0;
            cnt_d   = cnt_q + CNT_W'(1);
            // Hold on the frame's final byte so the address stays inside the frame.
            if (!last_o) addr_d = addr_q + ADDR_W'(1);
         end else begin
            phase_d = phase_q + 2'd1;
            addr_d  = addr_q + ADDR_W'(1);
         end
      end
      last_nxt_o = (cnt_d == npix_d - CNT_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         phase_q <= '0;
         cnt_q   <= '0;
         npix_q  <= '0;
      end else begin
         addr_q  <= addr_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         npix_q  <= npix_d;
      end
   end

   assign addr_o      = addr_q;
   assign phase_o     = phase_q;
   assign phase_nxt_o = phase_d;

endmodule

// File: rtl/gray_store_ctrl.sv
// Frame write sequencer: accepts grayscale pixels and writes each one as
// BYTES_PER_PIXEL identical bytes to consecutive addresses (GRAY_PACKED_EN: one byte).
module gray_store_ctrl
   import gray_store_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   gray_store_ctrl_if.slave bus,
   output state_e           state_o
);

   localparam int NEED_W = CNT_W + 2;

   state_e            state_q, state_d;
   logic [7:0]        pix_q, pix_d;
   logic              in_ready_q, in_ready_d;
   logic              mem_we_q, mem_we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              clear, advance, hs, start_ok;
   logic [NEED_W-1:0] need_bytes;
   logic [ADDR_W-1:0] addr;
   logic [1:0]        phase, phase_nxt;
   logic              last, last_nxt;

   assign need_bytes = NEED_W'(bus.npix) * NEED_W'(BYTES_PER_PIXEL);
   assign start_ok   = (bus.npix != '0) && (need_bytes <= NEED_W'(MEM_BYTES));
   assign hs         = bus.in_valid && in_ready_q;

   gray_store_addr_gen #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_addr_gen (
      .clk         (clk),
      .rst_n       (rst),
      .clear_i     (clear),
      .advance_i   (advance),
      .npix_i      (bus.npix),
      .addr_o      (addr),
      .phase_o     (phase),
      .phase_nxt_o (phase_nxt),
      .last_o      (last),
      .last_nxt_o  (last_nxt)
   );

   always_comb begin
      state_d = state_q;
      pix_d   = pix_q;
      clear   = 1'b0;
      advance = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (start_ok) begin
                  clear   = 1'b1;
                  state_d = RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (hs) begin
               pix_d   = bus.in_data;
               state_d = WRITE;
            end
         end
         WRITE: begin
            // The byte on the bus this cycle is always committed, even on abort.
            advance = 1'b1;
            if (bus.abort) begin
               state_d = IDLE;
            end else if (phase == LAST_PHASE) begin
               if (last) begin
                  state_d = DONE;
               end else if (hs) begin
                  pix_d   = bus.in_data;
                  state_d = WRITE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from next-cycle state so they leave the chip from flops.
      busy_d     = (state_d != IDLE);
      done_d     = (state_d == DONE);
      mem_we_d   = (state_d == WRITE);
      in_ready_d = (state_d == RUN) ||
                   ((state_d == WRITE) && (phase_nxt == LAST_PHASE) && !last_nxt);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         pix_q      <= '0;
         in_ready_q <= 1'b0;
         mem_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pix_q      <= pix_d;
         in_ready_q <= in_ready_d;
         mem_we_q   <= mem_we_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = addr;
   assign bus.mem_wdata = pix_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign state_o       = state_q;

endmodule

// File: doc/gray_store_ctrl.md
Name: gray_store_ctrl

Overview:
- Write sequencer between the RGB-to-grayscale converter output and the byte-wide result frame memory.
- Accepts one 8-bit grayscale pixel per valid/ready handshake.
- Writes each pixel as three identical bytes (R=G=B) to consecutive memory addresses, counts pixels against a programmed frame length, and signals frame completion.
- Replaces free-running store logic with bounded, restartable, abortable frame sequencing.

Parameters:
- MEM_BYTES, 51200, size of the result memory in bytes.
- ADDR_W, 16, memory address width; must satisfy 2^ADDR_W >= MEM_BYTES.
- CNT_W, 16, width of the pixel-count configuration.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches npix and begins a frame.
- npix  in  CNT_W  number of pixels in the frame; sampled only when start is accepted.
- abort  in  1  synchronous frame abort.
- in_valid  in  1  grayscale pixel valid.
- in_data  in  8  grayscale pixel.
- in_ready  out  1  controller accepts the pixel this cycle.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wdata  out  8  memory write data.
- busy  out  1  a frame is in progress.
- done  out  1  one-cycle pulse after the last byte of a frame is written.
- err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; address, pixel counter and phase cleared.
- States: IDLE, RUN, WRITE, DONE.
- IDLE:
  - start=1 with 1 <= npix and 3*npix <= MEM_BYTES (compute in CNT_W+2 bits): latch npix, clear address to 0, clear count, go to RUN.
  - Otherwise, start=1 pulses err for one cycle next cycle and the state stays IDLE.
- RUN:
  - in_ready=1.
  - Handshake in_valid&in_ready latches in_data, sets phase=0, goes to WRITE.
- WRITE (phases 0,1,2):
  - Each cycle mem_we=1, mem_wdata=latched pixel, mem_addr=current address; address increments by 1 after each write.
  - Pixel count increments on phase 2.
- Pipelined accept: in_ready=1 during phase 2 only if the pixel being written is not the last one.
  - A handshake then reloads the pixel and restarts at phase 0 with no bubble, giving 3 cycles per pixel sustained.
  - Without a handshake, phase 2 goes to RUN when pixels remain, or to DONE after the last pixel.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in RUN, WRITE and DONE; 0 in IDLE.
- Outputs are registered. mem_we is asserted in the cycle after the accepting handshake.
- Latency from the first accepted pixel to done is 3*npix+1 cycles, assuming back-to-back input.
- start while busy is ignored: no err, no effect.
- abort=1 in any non-IDLE state: next state IDLE, mem_we and in_ready drop next cycle, no done.
  - A write in flight that cycle completes; the remaining phases are not written.
- abort has priority over start and handshake in the same cycle. abort in IDLE has no effect.
- The address never exceeds 3*npix-1, so memory bounds are guaranteed by the start check.
- in_data is ignored whenever in_ready=0.

Optional Feature:
- Macro GRAY_PACKED_EN.
- Defined:
  - Each pixel is written once (single WRITE cycle, no phases).
  - Start check becomes npix <= MEM_BYTES.
  - in_ready stays high in WRITE unless the pixel is the last, giving 1 pixel per cycle.
  - Latency to done is npix+1 cycles.
- Undefined: three-byte replication as specified above.

Decomposition:
- Shared package gray_store_pkg holds:
  - the state enum (IDLE, RUN, WRITE, DONE);
  - the BYTES_PER_PIXEL localparam (3, or 1 under GRAY_PACKED_EN);
  - the default MEM_BYTES constant.
- One sub-module, gray_store_addr_gen: address register, phase counter and pixel counter with clear/advance inputs, and a last-pixel flag output. The FSM stays in the top module.

Test Plan:
- Single frame, npix=4, continuous in_valid with data 0x10,0x20,0x30,0x40 -> 12 writes at addresses 0..11 (0x10 x3 at 0-2, ... 0x40 x3 at 9-11) on consecutive cycles; done one cycle after address 11; busy falls with done.
- Sparse input, npix=2, in_valid gapped by 5 cycles -> in_ready high while waiting in RUN; addresses 0-5 written; no writes during gaps; done after the last write.
- Rejects: start with npix=0 -> err pulse, stays IDLE; start with npix=17067 (3*npix > 51200) -> err; npix=17066 -> accepted, last address 51197.
- Abort after 5 accepted pixels of npix=10 -> in_ready=0 and mem_we=0 the next cycle; no done; a new start with npix=1 writes from address 0.
- start pulsed mid-frame, plus reset pulled low during WRITE -> start ignored with no err; async reset clears all outputs immediately; post-reset frame starts at address 0.
- GRAY_PACKED_EN build, npix=3 with data 0xAA,0xBB,0xCC -> writes to addresses 0,1,2 on three consecutive cycles; done on the 4th cycle.
